regfile_writeback: RTL
======================

Name: regfile_writeback

Overview:
- Write-side companion of the integer register file: the single producer of the file's write port (`wen`, `rd`, `dataD`).
- Arbitrates between two result sources:
  - ALU: single-cycle, stallable.
  - LSU: load return, needs byte/half extraction and sign/zero extension.
- Keeps a per-register pending scoreboard so decode can stall on read-after-write hazards.
- Sits between execute/LSU and the register file, in the `clk` domain.

Parameters:
- `ADDR_WIDTH`, 5, register index width; the scoreboard has `1<<ADDR_WIDTH` entries.
- `DATA_WIDTH`, 32, write data width; load extraction is defined for 32 only (elaboration error otherwise).
- `STARVE_LIMIT`, 4, maximum consecutive LSU grants while the ALU waits.

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  synchronous reset, active-low
- `alu_valid`  in  1  ALU result valid
- `alu_ready`  out  1  ALU result accepted this cycle when `alu_valid` is also high
- `alu_rd`  in  ADDR_WIDTH  ALU destination register
- `alu_data`  in  DATA_WIDTH  ALU result
- `lsu_valid`  in  1  load data valid
- `lsu_ready`  out  1  load result accepted this cycle when `lsu_valid` is also high
- `lsu_rd`  in  ADDR_WIDTH  load destination register
- `lsu_raw`  in  32  aligned memory word
- `lsu_size`  in  2  load size: 0 byte, 1 half, 2 word, 3 reserved
- `lsu_unsigned`  in  1  1 = zero-extend, 0 = sign-extend
- `lsu_offset`  in  2  byte offset within the word
- `iss_valid`  in  1  an instruction with a destination issues
- `iss_rd`  in  ADDR_WIDTH  destination of the issuing instruction
- `rs1`, `rs2`  in  ADDR_WIDTH  decode source registers to check
- `rs1_busy`, `rs2_busy`  out  1  source register has a pending write (combinational)
- `wen`  out  1  register file write enable (registered)
- `rd`  out  ADDR_WIDTH  register file write index (registered)
- `dataD`  out  DATA_WIDTH  register file write data (registered)

Behaviour:
- **Reset** (`rst_n` = 0 at a `clk` edge):
  - `wen` = 0, `rd` = 0, `dataD` = 0.
  - All pending bits = 0, starvation counter = 0.
  - Reset overrides every other action in the same cycle.
- **Handshake:**
  - A transfer occurs when `valid` and `ready` are both high at a rising edge.
  - `ready` never depends on the same source's own `valid`.
  - Sources hold their fields stable while `valid` is high and `ready` is low.
- **Arbitration** (one accept per cycle):
  - `force_alu` = `starve_cnt` == `STARVE_LIMIT`.
  - `lsu_ready` = !`force_alu`.
  - `alu_ready` = !`lsu_valid` || `force_alu`.
  - `starve_cnt` increments on an LSU accept while `alu_valid` = 1.
  - `starve_cnt` clears on an ALU accept, or whenever `alu_valid` = 0.
  - `starve_cnt` saturates at `STARVE_LIMIT`.
- **Write output:**
  - Latency is 1 cycle: the accept at edge N gives `wen`/`rd`/`dataD` valid during cycle N+1.
  - `wen` = 1 only when an accept occurred and the accepted destination != 0.
  - A result with destination x0 is accepted and discarded: `wen` = 0 and `rd`/`dataD` hold their previous values.
  - With no accept, `wen` = 0 and `rd`/`dataD` hold.
- **Load extraction:**
  - Byte select = `lsu_raw[8*lsu_offset +: 8]`.
  - Half select = `lsu_raw[16*lsu_offset[1] +: 16]`; `lsu_offset[0]` is ignored.
  - Word returns `lsu_raw` unchanged.
  - The selected field is extended to 32 bits per `lsu_unsigned`.
  - Size 3 produces 0 and still writes.
- **Scoreboard:**
  - `pending[iss_rd]` is set on `iss_valid` when `iss_rd` != 0.
  - A pending bit clears when a write for that index is accepted (clear at the accept edge, not at the `wen` cycle).
  - Set and clear of the same index in the same cycle: set wins (a newer writer exists).
  - `pending[0]` is always 0.
  - `rsN_busy` = `pending[rsN]` (combinational); no bypass. Decode sees a register as free in the cycle `wen` is high, and the file itself handles write-before-read.
  - An accept for a non-pending register is legal and leaves its bit 0.

Decomposition:
- Shared package:
  - Load size encodings (`LS_BYTE`=0, `LS_HALF`=1, `LS_WORD`=2).
  - `DEFAULT_STARVE_LIMIT`.
- Sub-module `load_align`: purely combinational (raw, size, unsigned, offset) -> 32-bit value. It is instantiated once and unit-testable in isolation.
- Arbiter, output register and scoreboard stay in `regfile_writeback`.

Test Plan:
- **Reset:** hold `rst_n` = 0 with both valids high -> `wen` = 0, `rd` = 0, `dataD` = 0, all busy = 0.
- **Single writes:**
  - ALU `rd` = 5, data 0x1234 for one cycle -> next cycle `wen` = 1, `rd` = 5, `dataD` = 0x1234.
  - `rd` = 0 -> `alu_ready` = 1 and `wen` stays 0.
- **Load extension:** raw 0x80FF7F01:
  - offset 3, byte, signed -> 0xFFFFFF80.
  - offset 2, half, unsigned -> 0x000080FF.
  - offset 1, byte, signed -> 0x0000007F.
  - word -> 0x80FF7F01.
- **Arbitration and starvation:** `lsu_valid` and `alu_valid` both held high for 6 cycles -> grant sequence LSU, LSU, LSU, LSU, ALU, LSU; `alu_ready` low in cycles 0-3.
- **Scoreboard:**
  - Issue `rd` = 7 -> `rs1_busy` = 1 for `rs1` = 7 until the `rd` = 7 write is accepted, then 0.
  - Issue `rd` = 7 in the same cycle as an accept of `rd` = 7 -> stays busy.
  - Issue `rd` = 0 -> never busy.
- **Reset mid-operation:** 3 registers pending and `alu_valid` stalled by the LSU, then `rst_n` = 0 for 1 cycle -> all busy = 0, `wen` = 0, starvation counter restarts (ALU forced only after 4 new LSU grants).

Source files
------------

// File: rtl/regfile_writeback_pkg.sv
// Shared definitions for the register-file write-back block.
//   ls_size_e            : load size encodings carried on lsu_size
//   DEFAULT_STARVE_LIMIT : default cap on consecutive LSU grants while the ALU waits
package regfile_writeback_pkg;

  typedef enum logic [1:0] {
    LS_BYTE = 2'd0,
    LS_HALF = 2'd1,
    LS_WORD = 2'd2,
    LS_RSVD = 2'd3
  } ls_size_e;

  localparam int DEFAULT_STARVE_LIMIT = 4;

endpackage

// File: rtl/regfile_writeback_load_align.sv
// load_align: purely combinational load-data extraction.
//   raw    : aligned 32-bit memory word
//   size   : LS_BYTE / LS_HALF / LS_WORD (reserved encoding yields 0)
//   zext   : 1 = zero-extend, 0 = sign-extend
//   offset : byte offset within the word (bit 0 ignored for halves)
//   value  : extracted, extended 32-bit result
module load_align
  import regfile_writeback_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  size,
  input  logic        zext,
  input  logic [1:0]  offset,
  output logic [31:0] value
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'(raw >> {offset, 3'b000});
    half_sel = 16'(raw >> {offset[1], 4'b0000});
    value    = '0;
    case (ls_size_e'(size))
      LS_BYTE: value = {{24{~zext & byte_sel[7]}}, byte_sel};
      LS_HALF: value = {{16{~zext & half_sel[15]}}, half_sel};
      LS_WORD: value = raw;
      default: value = '0;
    endcase
  end

endmodule

// File: rtl/regfile_writeback.sv
// regfile_writeback: sole producer of the integer register file write port.
//   ALU / LSU valid-ready inputs : result sources, one accepted per cycle
//   iss_valid / iss_rd           : destination of an issuing instruction (sets pending)
//   rs1 / rs2 -> rs1_busy/rs2_busy : combinational pending lookup for decode
//   wen / rd / dataD             : registered write port, 1-cycle after accept
// The LSU normally wins; after STARVE_LIMIT consecutive LSU grants with the
// ALU waiting, the ALU is forced through for one grant.
module regfile_writeback
  import regfile_writeback_pkg::*;
#(
  parameter int ADDR_WIDTH   = 5,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [ADDR_WIDTH-1:0] alu_rd,
  input  logic [DATA_WIDTH-1:0] alu_data,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [ADDR_WIDTH-1:0] lsu_rd,
  input  logic [31:0]           lsu_raw,
  input  logic [1:0]            lsu_size,
  input  logic                  lsu_unsigned,
  input  logic [1:0]            lsu_offset,
  input  logic                  iss_valid,
  input  logic [ADDR_WIDTH-1:0] iss_rd,
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic                  wen,
  output logic [ADDR_WIDTH-1:0] rd,
  output logic [DATA_WIDTH-1:0] dataD
);

  localparam int NREG = 1 << ADDR_WIDTH;
  localparam int CW   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  if (DATA_WIDTH != 32) begin : g_width_chk
    $error("regfile_writeback: load extraction requires DATA_WIDTH == 32");
  end

  logic [CW-1:0]           starve_cnt;
  logic [NREG-1:0]         pending, pending_nxt;
  logic                    force_alu, alu_acc, lsu_acc, acc;
  logic [ADDR_WIDTH-1:0]   sel_rd;
  logic [DATA_WIDTH-1:0]   sel_data;
  logic [31:0]             load_val;

  load_align u_load_align (
    .raw    (lsu_raw),
    .size   (lsu_size),
    .zext   (lsu_unsigned),
    .offset (lsu_offset),
    .value  (load_val)
  );

  // Readies never look at their own source's valid, so the two accepts are
  // mutually exclusive by construction.
  assign force_alu = (starve_cnt == LIMIT);
  assign lsu_ready = ~force_alu;
  assign alu_ready = ~lsu_valid | force_alu;
  assign alu_acc   = alu_valid & alu_ready;
  assign lsu_acc   = lsu_valid & lsu_ready;
  assign acc       = alu_acc | lsu_acc;
  assign sel_rd    = alu_acc ? alu_rd   : lsu_rd;
  assign sel_data  = alu_acc ? alu_data : DATA_WIDTH'(load_val);

  // Clear on accept first, then set, so a new issuer of the same index wins.
  always_comb begin
    pending_nxt = pending;
    if (acc)
      pending_nxt[sel_rd] = 1'b0;
    if (iss_valid && iss_rd != '0)
      pending_nxt[iss_rd] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  assign rs1_busy = pending[rs1];
  assign rs2_busy = pending[rs2];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wen        <= 1'b0;
      rd         <= '0;
      dataD      <= '0;
      pending    <= '0;
      starve_cnt <= '0;
    end else begin
      pending <= pending_nxt;
      wen     <= acc && (sel_rd != '0);
      // x0 results are consumed but leave rd/dataD untouched.
      if (acc && sel_rd != '0) begin
        rd    <= sel_rd;
        dataD <= sel_data;
      end
      if (!alu_valid || alu_acc)
        starve_cnt <= '0;
      else if (lsu_acc && !force_alu)
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule
